cmem_dbuf: RTL and testbench

Double-buffered, multi-port coefficient memory for the filter datapath.
- Coefficients are shifted serially into a shadow register chain while the filter keeps reading a stable active bank.
- A commit handshake copies the shadow into the active bank, only at a frame boundary.
- NRD independent registered read ports serve parallel MAC lanes.

---
 rtl/cmem_dbuf.sv | 191 +++++++++++++++++++
 tb/tb_cmem_dbuf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cmem_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : cmem_dbuf
// Purpose  : Double-buffered, multi-port coefficient memory. Coefficients are
//            shifted serially into a shadow chain while the datapath reads a
//            stable active bank. A commit copies the shadow into the active
//            bank, and only at a frame boundary.
// Ports    : clk, rst_n        - clock (rising edge), async active-low reset
//            sde_in, sd_in     - serial shift enable / serial data in
//            sd_out            - shadow MSB, for daisy-chaining
//            commit_req_in     - request a shadow->active copy
//            frame_in          - frame boundary strobe, gates the commit
//            commit_ack_out    - one-cycle pulse after the active bank updates
//            pend_out          - commit accepted, waiting for frame_in
//            full_out          - shadow holds DEPTH*WIDTH fresh bits
//            load_err_out      - sticky error (early commit / shift while pending)
//            addr_in, d_out    - NRD registered read ports, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module cmem_dbuf #(
  parameter int DEPTH = 4,  // coefficient words
  parameter int WIDTH = 8,  // bits per coefficient word
  parameter int NRD   = 2   // independent read ports (1..8)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sde_in,
  input  logic                        sd_in,
  output logic                        sd_out,
  input  logic                        commit_req_in,
  input  logic                        frame_in,
  output logic                        commit_ack_out,
  output logic                        pend_out,
  output logic                        full_out,
  output logic                        load_err_out,
  input  logic [NRD*((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr_in,
  output logic [NRD*WIDTH-1:0]        d_out
);

  // Address width is derived from DEPTH and must not be overridden.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int N  = DEPTH * WIDTH;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] c_N     = N[CW-1:0];
  localparam logic [AW:0]   c_DEPTH = DEPTH[AW:0];

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_PEND = 1'b1;

  logic [N-1:0]  r_shadow;
  logic [N-1:0]  r_active;
  logic [CW-1:0] r_cnt;
  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic          r_ack;
  logic          r_err;

  logic          w_full;
  logic          w_shift;
  logic          w_commit;
  logic          w_set_err;
  logic          w_pend;

  assign w_full = (r_cnt == c_N);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (commit_req_in && w_full && !frame_in) begin
          w_state_nxt = c_PEND;
        end
      end
      c_PEND: begin
        if (frame_in) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_shift   = 1'b0;
    w_commit  = 1'b0;
    w_set_err = 1'b0;
    w_pend    = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_shift = sde_in;
        if (commit_req_in) begin
          // An incomplete shadow is never committed; the request is dropped.
          w_set_err = !w_full;
          w_commit  = w_full && frame_in;
        end
      end
      c_PEND: begin
        w_pend    = 1'b1;
        w_commit  = frame_in;
        // The shadow is frozen while a commit is outstanding.
        w_set_err = sde_in;
      end
      default: begin
        w_pend = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shadow chain, bit counter, active bank, status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_shift) begin
        r_shadow <= {r_shadow[N-2:0], sd_in};
      end
      // Commit copies the pre-shift shadow and restarts the fill count.
      if (w_commit) begin
        r_active <= r_shadow;
        r_cnt    <= '0;
      end else if (w_shift && !w_full) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_ack <= w_commit;
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign sd_out         = r_shadow[N-1];
  assign full_out       = w_full;
  assign pend_out       = w_pend;
  assign commit_ack_out = r_ack;
  assign load_err_out   = r_err;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_words [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign w_words[i] = r_active[i*WIDTH +: WIDTH];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] r_rd;

    assign w_addr = addr_in[k*AW +: AW];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd <= '0;
      end else if ({1'b0, w_addr} < c_DEPTH) begin
        r_rd <= w_words[w_addr];
      end else begin
        // Addresses past the last word (non-power-of-2 DEPTH) read as zero.
        r_rd <= '0;
      end
    end

    assign d_out[k*WIDTH +: WIDTH] = r_rd;
  end

endmodule
`default_nettype wire

// File: tb/tb_cmem_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmem_dbuf
// Purpose  : Directed self-checking bench for cmem_dbuf (DEPTH=4, WIDTH=8,
//            NRD=2). Inputs change 1 ns after a rising edge; outputs are
//            sampled at that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmem_dbuf;

  logic        clk;
  logic        rst_n;
  logic        sde_in;
  logic        sd_in;
  logic        sd_out;
  logic        commit_req_in;
  logic        frame_in;
  logic        commit_ack_out;
  logic        pend_out;
  logic        full_out;
  logic        load_err_out;
  logic [3:0]  addr_in;
  logic [15:0] d_out;

  int checks   = 0;
  int failures = 0;

  cmem_dbuf #(
    .DEPTH (4),
    .WIDTH (8),
    .NRD   (2)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sde_in         (sde_in),
    .sd_in          (sd_in),
    .sd_out         (sd_out),
    .commit_req_in  (commit_req_in),
    .frame_in       (frame_in),
    .commit_ack_out (commit_ack_out),
    .pend_out       (pend_out),
    .full_out       (full_out),
    .load_err_out   (load_err_out),
    .addr_in        (addr_in),
    .d_out          (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shift the first nbits of val, MSB first, so a full 32-bit load leaves
  // val[31:24] in word 3 and val[7:0] in word 0.
  task automatic shift_bits(input logic [31:0] val, input int nbits);
    sde_in = 1'b1;
    for (int i = 31; i > 31 - nbits; i--) begin
      sd_in = val[i];
      tick();
    end
    sde_in = 1'b0;
    sd_in  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sde_in = 1'b0; sd_in = 1'b0;
    commit_req_in = 1'b0; frame_in = 1'b0; addr_in = 4'h0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_dout",  {16'h0, d_out},    32'h0);
    check("rst_sdout", {31'h0, sd_out},   32'h0);
    check("rst_full",  {31'h0, full_out}, 32'h0);
    check("rst_err",   {31'h0, load_err_out}, 32'h0);
    check("rst_pend",  {31'h0, pend_out}, 32'h0);
    rst_n = 1'b1;
    addr_in = {2'd1, 2'd0}; tick();
    check("rd0_1_empty", {16'h0, d_out}, 32'h0);
    addr_in = {2'd3, 2'd2}; tick();
    check("rd2_3_empty", {16'h0, d_out}, 32'h0);

    // ---------------- first load + immediate commit ----------------
    shift_bits(32'h44332211, 32);
    check("full_after32", {31'h0, full_out}, 32'h1);
    check("sdout_msb0",   {31'h0, sd_out},   32'h0);
    commit_req_in = 1'b1; frame_in = 1'b1; addr_in = {2'd3, 2'd0};
    tick();
    commit_req_in = 1'b0; frame_in = 1'b0;
    check("ack_pulse",     {31'h0, commit_ack_out}, 32'h1);
    check("full_cleared",  {31'h0, full_out},       32'h0);
    check("old_data_edge", {16'h0, d_out},          32'h0);
    tick();
    check("ack_one_cycle", {31'h0, commit_ack_out}, 32'h0);
    check("rd_3_0",        {16'h0, d_out},          32'h4411);
    addr_in = {2'd0, 2'd3}; tick();
    check("rd_0_3",        {16'h0, d_out},          32'h1144);

    // ---------------- pending commit ----------------
    shift_bits(32'hA4A3A2A1, 32);
    check("full_A",     {31'h0, full_out}, 32'h1);
    commit_req_in = 1'b1; tick(); commit_req_in = 1'b0;
    check("pend_set",   {31'h0, pend_out},       32'h1);
    check("pend_noack", {31'h0, commit_ack_out}, 32'h0);
    addr_in = {2'd1, 2'd0}; tick();
    check("pend_old_rd", {16'h0, d_out}, 32'h2211);
    check("sdout_msbA",  {31'h0, sd_out}, 32'h1);
    sde_in = 1'b1; sd_in = 1'b1; tick(); sde_in = 1'b0; sd_in = 1'b0;
    check("pend_shift_err",  {31'h0, load_err_out}, 32'h1);
    check("pend_shadow_frz", {31'h0, sd_out},       32'h1);
    check("pend_full_frz",   {31'h0, full_out},     32'h1);
    repeat (4) tick();
    check("still_pend", {31'h0, pend_out}, 32'h1);
    frame_in = 1'b1; tick(); frame_in = 1'b0;
    check("pend_ack",   {31'h0, commit_ack_out}, 32'h1);
    check("pend_clear", {31'h0, pend_out},       32'h0);
    addr_in = {2'd2, 2'd1}; tick();
    check("rd_2_1_A",   {16'h0, d_out}, 32'hA3A2);

    // ---------------- read across a commit edge ----------------
    shift_bits(32'h55667788, 32);
    addr_in = {2'd1, 2'd1};
    commit_req_in = 1'b1; frame_in = 1'b1; tick();
    commit_req_in = 1'b0; frame_in = 1'b0;
    check("cross_old", {16'h0, d_out}, 32'hA2A2);
    tick();
    check("cross_new", {16'h0, d_out}, 32'h7777);

    // ---------------- async reset while pending ----------------
    shift_bits(32'h92345678, 32);
    commit_req_in = 1'b1; tick(); commit_req_in = 1'b0;
    check("pend_before_rst", {31'h0, pend_out}, 32'h1);
    check("sdout_before_rst", {31'h0, sd_out},  32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", {16'h0, d_out},           32'h0);
    check("arst_sd",   {31'h0, sd_out},          32'h0);
    check("arst_pend", {31'h0, pend_out},        32'h0);
    check("arst_full", {31'h0, full_out},        32'h0);
    check("arst_err",  {31'h0, load_err_out},    32'h0);
    check("arst_ack",  {31'h0, commit_ack_out},  32'h0);
    tick();
    rst_n = 1'b1;
    shift_bits(32'hCAFEBABE, 32);
    addr_in = {2'd3, 2'd0};
    commit_req_in = 1'b1; frame_in = 1'b1; tick();
    commit_req_in = 1'b0; frame_in = 1'b0;
    check("post_rst_ack", {31'h0, commit_ack_out}, 32'h1);
    tick();
    check("post_rst_rd",  {16'h0, d_out},          32'hCABE);
    check("post_rst_err", {31'h0, load_err_out},   32'h0);

    // ---------------- early commit after 20 shifts ----------------
    shift_bits(32'h0F0F0F0F, 20);
    check("partial_notfull", {31'h0, full_out}, 32'h0);
    commit_req_in = 1'b1; frame_in = 1'b1; tick();
    commit_req_in = 1'b0; frame_in = 1'b0;
    check("early_err",   {31'h0, load_err_out},   32'h1);
    check("early_noack", {31'h0, commit_ack_out}, 32'h0);
    check("early_nopend", {31'h0, pend_out},      32'h0);
    tick();
    check("early_rd",    {16'h0, d_out},          32'hCABE);
    addr_in = {2'd2, 2'd1}; tick();
    check("early_rd_2_1", {16'h0, d_out},         32'hFEBA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
